// File: rtl/mac_tx_arb_pkg.sv
// Shared types and constants for the MAC TX arbiter.
// State encoding, grant encodings, default timing constants and the
// per-requester byte beat bundle.
package mac_tx_arb_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        ACK  = 3'd2,
        SEND = 3'd3,
        IFG  = 3'd4
    } arb_state_e;

    localparam logic GRANT_ARP = 1'b0;
    localparam logic GRANT_IP  = 1'b1;

    localparam int unsigned IFG_CYCLES_DEF     = 12;
    localparam logic [15:0] TIMEOUT_CYCLES_DEF = 16'd65535;

    // One byte slot of a requester's stream.
    typedef struct packed {
        logic       ready;
        logic [7:0] data;
        logic       last;
    } tx_beat_t;

endpackage

// File: rtl/mac_tx_rr_pick.sv
// Combinational 2-way round-robin chooser.
// With both requests pending the side that did not win last time wins;
// a lone request wins regardless of history.
module mac_tx_rr_pick
    import mac_tx_arb_pkg::*;
(
    input  logic arp_req,
    input  logic ip_req,
    input  logic last_grant,
    output logic valid,
    output logic winner
);

    // Pick a winner from the current request levels.
    always_comb begin
        valid = arp_req | ip_req;
        if (arp_req && ip_req) begin
            winner = ~last_grant;
        end else if (ip_req) begin
            winner = GRANT_IP;
        end else begin
            winner = GRANT_ARP;
        end
    end

endmodule

// File: rtl/mac_tx_arbiter.sv
// MAC TX arbiter: round-robin scheduler between the ARP and IP
// transmitters in front of mac_tx. Owns the req/ack handshake toward
// mac_tx, steers the winner's bytes through one register stage, holds
// the grant until mac_send_end and then enforces an inter-frame gap.
// Optional watchdog on REQ/SEND stalls enabled by MAC_TX_ARB_TIMEOUT_EN.
module mac_tx_arbiter
    import mac_tx_arb_pkg::*;
#(
    parameter int unsigned IFG_CYCLES     = IFG_CYCLES_DEF,
    parameter logic [15:0] TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       arp_tx_req,
    input  logic       arp_tx_ready,
    input  logic [7:0] arp_tx_data,
    input  logic       arp_tx_end,
    output logic       arp_tx_ack,
    input  logic       ip_tx_req,
    input  logic       ip_tx_ready,
    input  logic [7:0] ip_tx_data,
    input  logic       ip_tx_end,
    output logic       ip_tx_ack,
    output logic       mac_tx_req,
    input  logic       mac_tx_ack,
    output logic       mac_tx_ready,
    output logic [7:0] mac_tx_data,
    output logic       mac_tx_end,
    input  logic       mac_send_end,
    output logic       arb_busy,
    output logic       arb_timeout
);

    // Last count value of the gap; a zero gap still spends one cycle in IFG.
    localparam logic [7:0] IFG_LAST = (IFG_CYCLES == 0) ? 8'd0 : 8'(IFG_CYCLES - 1);

    arb_state_e state_q, state_d;
    logic       grant_q, grant_d;
    logic       last_grant_q, last_grant_d;
    logic [7:0] ifg_cnt_q, ifg_cnt_d;
    logic       pick_valid, pick_winner;
    logic       win_req;
    logic       wdog_fire;
    tx_beat_t   arp_beat, ip_beat, sel_beat, beat_q;

    mac_tx_rr_pick u_pick (
        .arp_req    (arp_tx_req),
        .ip_req     (ip_tx_req),
        .last_grant (last_grant_q),
        .valid      (pick_valid),
        .winner     (pick_winner)
    );

    assign win_req  = (grant_q == GRANT_IP) ? ip_tx_req : arp_tx_req;
    assign arp_beat = {arp_tx_ready, arp_tx_data, arp_tx_end};
    assign ip_beat  = {ip_tx_ready, ip_tx_data, ip_tx_end};
    assign sel_beat = (grant_q == GRANT_IP) ? ip_beat : arp_beat;

`ifdef MAC_TX_ARB_TIMEOUT_EN
    logic [15:0] wdog_q;
    logic        wdog_run;
    logic        wdog_hit;
    logic        timeout_q;

    assign wdog_run = (state_q == REQ) || (state_q == SEND);
    assign wdog_hit = wdog_run && (wdog_q == TIMEOUT_CYCLES - 16'd1);
    // An ack or a cancel in REQ takes precedence over the watchdog.
    assign wdog_fire = wdog_hit && !((state_q == REQ) && (mac_tx_ack || !win_req));

    // Stall counter: runs in REQ/SEND, saturates, clears on any state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_q    <= 16'd0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= wdog_fire;
            if (state_d != state_q) begin
                wdog_q <= 16'd0;
            end else if (wdog_run && (wdog_q != 16'hFFFF)) begin
                wdog_q <= wdog_q + 16'd1;
            end
        end
    end

    assign arb_timeout = timeout_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign wdog_fire      = 1'b0;
    assign arb_timeout    = 1'b0;
`endif

    // FSM state and grant bookkeeping registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= GRANT_ARP;
            last_grant_q <= GRANT_IP;
            ifg_cnt_q    <= 8'd0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            ifg_cnt_q    <= ifg_cnt_d;
        end
    end

    // Next-state logic; grant history only moves when a frame is accepted
    // or the watchdog gives up on a stalled grant.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        ifg_cnt_d    = ifg_cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_winner;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (mac_tx_ack) begin
                    last_grant_d = grant_q;
                    state_d      = ACK;
                end else if (!win_req) begin
                    state_d = IDLE;
                end else if (wdog_fire) begin
                    last_grant_d = grant_q;
                    state_d      = IDLE;
                end
            end
            ACK: begin
                state_d = SEND;
            end
            SEND: begin
                if (mac_send_end || wdog_fire) begin
                    state_d = IFG;
                end
            end
            IFG: begin
                if (ifg_cnt_q == IFG_LAST) begin
                    ifg_cnt_d = 8'd0;
                    state_d   = IDLE;
                end else begin
                    ifg_cnt_d = ifg_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // One-stage steering register; anything outside SEND registers as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_q <= '0;
        end else if (state_q == SEND) begin
            beat_q <= sel_beat;
        end else begin
            beat_q <= '0;
        end
    end

    assign mac_tx_req   = (state_q == REQ);
    assign arp_tx_ack   = (state_q == ACK) && (grant_q == GRANT_ARP);
    assign ip_tx_ack    = (state_q == ACK) && (grant_q == GRANT_IP);
    assign arb_busy     = (state_q != IDLE);
    assign mac_tx_ready = beat_q.ready;
    assign mac_tx_data  = beat_q.data;
    assign mac_tx_end   = beat_q.last;

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// Self-checking bench for mac_tx_arbiter. Inputs change and outputs are
// sampled on the falling edge. A round-robin history bit plus the frame
// timing rules (1-cycle request/ack latency, 1-cycle datapath, IFG+2 gap)
// give the expected values. The watchdog section follows
// MAC_TX_ARB_TIMEOUT_EN.
module tb_mac_tx_arbiter;
    import mac_tx_arb_pkg::*;

    localparam int IFG = 12;
    localparam int TO  = 100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       arp_tx_req = 0, arp_tx_ready = 0, arp_tx_end = 0;
    logic [7:0] arp_tx_data = 0;
    logic       ip_tx_req = 0, ip_tx_ready = 0, ip_tx_end = 0;
    logic [7:0] ip_tx_data = 0;
    logic       mac_tx_ack = 0, mac_send_end = 0;
    logic       arp_tx_ack, ip_tx_ack, mac_tx_req, mac_tx_ready, mac_tx_end;
    logic [7:0] mac_tx_data;
    logic       arb_busy, arb_timeout;

    int   n_checks = 0;
    int   n_errors = 0;
    logic model_last;   // round-robin history: who was accepted last

    mac_tx_arbiter #(.IFG_CYCLES(IFG), .TIMEOUT_CYCLES(16'(TO))) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .arp_tx_req   (arp_tx_req),
        .arp_tx_ready (arp_tx_ready),
        .arp_tx_data  (arp_tx_data),
        .arp_tx_end   (arp_tx_end),
        .arp_tx_ack   (arp_tx_ack),
        .ip_tx_req    (ip_tx_req),
        .ip_tx_ready  (ip_tx_ready),
        .ip_tx_data   (ip_tx_data),
        .ip_tx_end    (ip_tx_end),
        .ip_tx_ack    (ip_tx_ack),
        .mac_tx_req   (mac_tx_req),
        .mac_tx_ack   (mac_tx_ack),
        .mac_tx_ready (mac_tx_ready),
        .mac_tx_data  (mac_tx_data),
        .mac_tx_end   (mac_tx_end),
        .mac_send_end (mac_send_end),
        .arb_busy     (arb_busy),
        .arb_timeout  (arb_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL tb_timeout: got hang, expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [14:0] outs();
        return {arp_tx_ack, ip_tx_ack, mac_tx_req, mac_tx_ready, mac_tx_data,
                mac_tx_end, arb_busy, arb_timeout};
    endfunction

    function automatic logic pick(input logic a, input logic i);
        if (a && i) return ~model_last;
        return i ? GRANT_IP : GRANT_ARP;
    endfunction

    task automatic drop_req(input logic w);
        if (w == GRANT_ARP) arp_tx_req = 1'b0;
        else                ip_tx_req  = 1'b0;
    endtask

    task automatic drive(input logic w, input logic [9:0] wv, input logic [9:0] lv);
        if (w == GRANT_ARP) begin
            {arp_tx_ready, arp_tx_data, arp_tx_end} = wv;
            {ip_tx_ready, ip_tx_data, ip_tx_end}    = lv;
        end else begin
            {ip_tx_ready, ip_tx_data, ip_tx_end}    = wv;
            {arp_tx_ready, arp_tx_data, arp_tx_end} = lv;
        end
    endtask

    task automatic wait_req(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mac_tx_req && n < 300);
        chk("req_seen", mac_tx_req, 1);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (arb_busy && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("idle_reach", arb_busy, 0);
    endtask

    // Called on the falling edge where mac_tx_req was first seen. Returns two
    // falling edges after the one that drove mac_send_end.
    task automatic run_frame(input logic w, input int nbytes, input int ack_dly,
                             input bit hold, input bit ack_drop);
        logic [9:0] exp, wv;
        logic       rdy;
        int         sent;
        chk("req_up", mac_tx_req, 1);
        for (int i = 0; i < ack_dly; i++) begin
            mac_send_end = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("req_hold", mac_tx_req, 1);
            chk("ack_early", {arp_tx_ack, ip_tx_ack}, 0);
        end
        mac_send_end = 1'b0;
        mac_tx_ack   = 1'b1;
        if (ack_drop) drop_req(w);
        @(negedge clk);
        mac_tx_ack = 1'b0;
        chk("arp_ack", arp_tx_ack, w == GRANT_ARP);
        chk("ip_ack", ip_tx_ack, w == GRANT_IP);
        chk("req_after_ack", mac_tx_req, 0);
        model_last = w;
        if (!hold) drop_req(w);
        drive(w, 10'($urandom), 10'($urandom));
        exp  = '0;
        sent = 0;
        while (sent < nbytes) begin
            @(negedge clk);
            chk("send_out", {mac_tx_ready, mac_tx_data, mac_tx_end}, exp);
            chk("send_ctl", {arb_busy, mac_tx_req, arp_tx_ack, ip_tx_ack, arb_timeout}, 5'b10000);
            rdy = ($urandom_range(0, 3) != 0);
            wv  = {rdy, 8'($urandom), rdy && (sent == nbytes - 1)};
            drive(w, wv, 10'($urandom));
            exp = wv;
            if (rdy) sent++;
        end
        @(negedge clk);
        chk("send_out", {mac_tx_ready, mac_tx_data, mac_tx_end}, exp);
        drive(w, 10'd0, 10'($urandom));
        mac_send_end = 1'b1;
        @(negedge clk);
        chk("tail_out", {mac_tx_ready, mac_tx_data, mac_tx_end}, 0);
        mac_send_end = 1'b0;
        drive(w, 10'($urandom), 10'($urandom));
        @(negedge clk);
        chk("ifg_out_zero", {mac_tx_ready, mac_tx_data, mac_tx_end}, 0);
        chk("ifg_busy", arb_busy, 1);
        drive(w, 10'd0, 10'd0);
    endtask

    initial begin
        int   n, pat, mode;
        logic w;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_outs", outs(), 0);
        rst_n      = 1'b1;
        model_last = GRANT_IP;
        @(negedge clk);
        chk("idle_outs", outs(), 0);

        // ARP alone, 60 bytes, then exact IFG length
        arp_tx_req = 1'b1;
        @(negedge clk);
        chk("arp_lat", mac_tx_req, 1);
        run_frame(GRANT_ARP, 60, 2, 0, 0);
        repeat (IFG - 2) @(negedge clk);
        chk("ifg_last_busy", arb_busy, 1);
        @(negedge clk);
        chk("ifg_done", arb_busy, 0);

        // Fresh reset, both together: ARP first, IP IFG+2 after send_end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n      = 1'b1;
        model_last = GRANT_IP;
        arp_tx_req = 1'b1;
        ip_tx_req  = 1'b1;
        wait_req(n);
        chk("both_lat", n, 1);
        w = pick(1'b1, 1'b1);
        chk("first_winner", w, GRANT_ARP);
        run_frame(w, $urandom_range(1, 12), $urandom_range(0, 3), 0, 0);
        wait_req(n);
        chk("ifg_gap", n, IFG);
        run_frame(pick(arp_tx_req, ip_tx_req), $urandom_range(1, 12), 1, 0, 0);
        wait_idle();

        // Both held for four frames
        arp_tx_req = 1'b1;
        ip_tx_req  = 1'b1;
        for (int f = 0; f < 4; f++) begin
            wait_req(n);
            chk("rr_lat", n, (f == 0) ? 1 : IFG);
            w = pick(1'b1, 1'b1);
            chk("rr_order", w, (f % 2 == 0) ? GRANT_ARP : GRANT_IP);
            run_frame(w, $urandom_range(1, 8), $urandom_range(0, 3), 1, 0);
        end
        arp_tx_req = 1'b0;
        ip_tx_req  = 1'b0;
        wait_idle();

        // IP cancelled in REQ leaves history alone
        arp_tx_req = 1'b1;
        wait_req(n);
        run_frame(GRANT_ARP, 4, 0, 0, 0);
        wait_idle();
        ip_tx_req = 1'b1;
        wait_req(n);
        chk("cancel_lat", n, 1);
        ip_tx_req = 1'b0;
        @(negedge clk);
        chk("cancel_req", mac_tx_req, 0);
        chk("cancel_busy", arb_busy, 0);
        repeat (3) begin
            @(negedge clk);
            chk("cancel_noack", {ip_tx_ack, arp_tx_ack, mac_tx_req}, 0);
        end
        arp_tx_req = 1'b1;
        ip_tx_req  = 1'b1;
        wait_req(n);
        w = pick(1'b1, 1'b1);
        chk("post_cancel_winner", w, GRANT_IP);
        run_frame(w, 5, 1, 0, 0);
        wait_req(n);
        chk("arp_after", n, IFG);
        run_frame(GRANT_ARP, 5, 0, 0, 0);
        wait_idle();

        // Randomized request patterns, cancels and ack-with-drop
        for (int it = 0; it < 24; it++) begin
            pat        = $urandom_range(1, 3);
            arp_tx_req = pat[0];
            ip_tx_req  = pat[1];
            w          = pick(pat[0], pat[1]);
            wait_req(n);
            chk("rand_lat", n, 1);
            mode = $urandom_range(0, 9);
            if (mode == 0) begin
                arp_tx_req = 1'b0;
                ip_tx_req  = 1'b0;
                @(negedge clk);
                chk("rand_cancel", {mac_tx_req, arb_busy, arp_tx_ack, ip_tx_ack}, 0);
            end else begin
                run_frame(w, $urandom_range(1, 16), $urandom_range(0, 4), 0, mode == 1);
                arp_tx_req = 1'b0;
                ip_tx_req  = 1'b0;
            end
            wait_idle();
        end

        // Stall in SEND with IP waiting
        arp_tx_req = 1'b1;
        wait_req(n);
        mac_tx_ack = 1'b1;
        @(negedge clk);
        mac_tx_ack = 1'b0;
        arp_tx_req = 1'b0;
        ip_tx_req  = 1'b1;
        model_last = GRANT_ARP;
        chk("stall_ack", arp_tx_ack, 1);
`ifdef MAC_TX_ARB_TIMEOUT_EN
        for (int c = 1; c <= TO + 2; c++) begin
            @(negedge clk);
            chk("wdog_send", arb_timeout, c == TO + 1);
        end
        wait_req(n);
        chk("wdog_next", n, IFG);
        run_frame(GRANT_IP, 3, 0, 0, 0);
        wait_idle();
        // Stall in REQ: timeout drops the request and flips history
        arp_tx_req = 1'b1;
        wait_req(n);
        for (int c = 1; c <= TO; c++) begin
            @(negedge clk);
            chk("wdog_req", arb_timeout, c == TO);
        end
        chk("wdog_req_drop", mac_tx_req, 0);
        model_last = GRANT_ARP;
        ip_tx_req  = 1'b1;
        wait_req(n);
        chk("wdog_req_lat", n, 1);
        w = pick(1'b1, 1'b1);
        chk("wdog_flip", w, GRANT_IP);
        run_frame(w, 3, 1, 0, 0);
        wait_req(n);
        run_frame(GRANT_ARP, 3, 1, 0, 0);
        wait_idle();
`else
        for (int c = 1; c <= 120; c++) begin
            @(negedge clk);
            chk("no_wdog", {arb_timeout, arb_busy, mac_tx_req}, 3'b010);
        end
        mac_send_end = 1'b1;
        @(negedge clk);
        mac_send_end = 1'b0;
        wait_req(n);
        chk("stall_next", n, IFG + 1);
        run_frame(GRANT_IP, 3, 0, 0, 0);
        wait_idle();
`endif

        // Reset mid-SEND of an ARP frame, then ARP regains priority
        arp_tx_req = 1'b1;
        wait_req(n);
        mac_tx_ack = 1'b1;
        @(negedge clk);
        mac_tx_ack = 1'b0;
        arp_tx_req = 1'b0;
        {arp_tx_ready, arp_tx_data, arp_tx_end} = {1'b1, 8'hA5, 1'b0};
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_data", {mac_tx_ready, mac_tx_data}, 9'h1A5);
        #2 rst_n = 1'b0;
        #1 chk("rst_async", outs(), 0);
        {arp_tx_ready, arp_tx_data, arp_tx_end} = '0;
        @(negedge clk);
        chk("rst_hold", outs(), 0);
        rst_n      = 1'b1;
        model_last = GRANT_IP;
        arp_tx_req = 1'b1;
        ip_tx_req  = 1'b1;
        wait_req(n);
        chk("post_rst_lat", n, 1);
        w = pick(1'b1, 1'b1);
        chk("post_rst_winner", w, GRANT_ARP);
        run_frame(w, 4, 0, 0, 0);
        wait_req(n);
        run_frame(GRANT_IP, 4, 0, 0, 0);
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
